// File: rtl/scan_hex_led_disp_n.sv
// Scanned N-digit hex 7-segment display driver.
// Shows a frame-consistent snapshot of the inputs, with per-digit blanking,
// leading-zero suppression, PWM brightness and a frame-start strobe.
// en_o and sseg_o are both active-low.
`timescale 1ns/1ps
module scan_hex_led_disp_n #(
  parameter int N_DIGITS    = 8,
  parameter int DIGIT_TICKS = 50000,
  parameter int BRIGHT_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] hex_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  input  logic [N_DIGITS-1:0]   blank_i,
  input  logic                  lz_en_i,
  input  logic [BRIGHT_W-1:0]   bright_i,
  output logic [N_DIGITS-1:0]   en_o,
  output logic [7:0]            sseg_o,
  output logic                  frame_tick_o
);

  localparam int TICK_W = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int IDX_W  = $clog2(N_DIGITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);

  // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  // Scan position and PWM phase
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [BRIGHT_W-1:0]   pwm_q, pwm_d;
  // Frame snapshot of the inputs
  logic [4*N_DIGITS-1:0] hex_s_q, hex_s_d;
  logic [N_DIGITS-1:0]   dp_s_q, dp_s_d;
  logic [N_DIGITS-1:0]   blank_s_q, blank_s_d;
  logic                  lz_en_s_q, lz_en_s_d;
  logic [BRIGHT_W-1:0]   bright_s_q, bright_s_d;
  // Registered pin drivers
  logic [N_DIGITS-1:0]   en_q, en_d;
  logic [7:0]            sseg_q, sseg_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  tick_wrap, snap, lz_run, cur_dp, cur_dark, lit;
  logic [3:0]            cur_hex;
  logic [N_DIGITS-1:0]   lz_sup;

  // Next-state: scan counters, snapshot capture and the decoded digit drive.
  // The first slot of a frame decodes straight from the inputs being
  // captured, so the whole frame (including its first cycle) shows one
  // consistent snapshot.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    tick_wrap = (tick_q == TICK_LAST);
    snap      = (tick_q == '0) && (idx_q == '0);

    tick_d = tick_wrap ? '0 : tick_q + TICK_W'(1);
    idx_d  = idx_q;
    if (tick_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    pwm_d  = tick_wrap ? '0 : pwm_q + BRIGHT_W'(1);

    hex_s_d      = snap ? hex_i    : hex_s_q;
    dp_s_d       = snap ? dp_i     : dp_s_q;
    blank_s_d    = snap ? blank_i  : blank_s_q;
    lz_en_s_d    = snap ? lz_en_i  : lz_en_s_q;
    bright_s_d   = snap ? bright_i : bright_s_q;
    frame_tick_d = snap;

    // Suppression runs down from the top digit and stops at the first
    // non-zero digit or lit decimal point; digit 0 is never suppressed.
    lz_sup = '0;
    lz_run = lz_en_s_d;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      lz_run    = lz_run && (hex_s_d[4*i +: 4] == 4'h0) && !dp_s_d[i];
      lz_sup[i] = lz_run;
    end

    cur_hex  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_hex  = hex_s_d[4*i +: 4];
        cur_dp   = dp_s_d[i];
        cur_dark = blank_s_d[i] || lz_sup[i];
      end
    end
    lit = !cur_dark && (pwm_q <= bright_s_d);

    en_d   = '1;
    sseg_d = 8'hFF;
    if (lit) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) en_d[i] = 1'b0;
      end
      sseg_d = {~cur_dp, ~hex_to_seg(cur_hex)};
    end
  end

  // State and output registers; synchronous reset blanks the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_q       <= '0;
      idx_q        <= '0;
      pwm_q        <= '0;
      hex_s_q      <= '0;
      dp_s_q       <= '0;
      blank_s_q    <= '0;
      lz_en_s_q    <= 1'b0;
      bright_s_q   <= '0;
      en_q         <= '1;
      sseg_q       <= 8'hFF;
      frame_tick_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      tick_q       <= tick_d;
      idx_q        <= idx_d;
      pwm_q        <= pwm_d;
      hex_s_q      <= hex_s_d;
      dp_s_q       <= dp_s_d;
      blank_s_q    <= blank_s_d;
      lz_en_s_q    <= lz_en_s_d;
      bright_s_q   <= bright_s_d;
      en_q         <= en_d;
      sseg_q       <= sseg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign en_o         = en_q;
  assign sseg_o       = sseg_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_scan_hex_led_disp_n.sv
// Self-checking bench for scan_hex_led_disp_n (N_DIGITS=4, DIGIT_TICKS=4, BRIGHT_W=2).
// A cycle-count based display model is compared with the DUT on every cycle,
// and literal expectations pin the main display cases.
`timescale 1ns/1ps
module tb_scan_hex_led_disp_n;
  localparam int N     = 4;
  localparam int DT    = 4;
  localparam int BW    = 2;
  localparam int FRAME = N * DT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] hex;
  logic [3:0]  dp, blank;
  logic        lz_en;
  logic [1:0]  bright;
  logic [3:0]  en;
  logic [7:0]  sseg;
  logic        frame_tick;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  scan_hex_led_disp_n #(.N_DIGITS(N), .DIGIT_TICKS(DT), .BRIGHT_W(BW)) dut (
    .clk(clk), .reset(reset),
    .hex_i(hex), .dp_i(dp), .blank_i(blank), .lz_en_i(lz_en), .bright_i(bright),
    .en_o(en), .sseg_o(sseg), .frame_tick_o(frame_tick)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int         c;
  int         last_phase = -1;
  bit         chk_on = 0;
  logic [3:0] exp_en;
  logic [7:0] exp_sseg;
  logic       exp_ft;
  logic [15:0] sh_hex;
  logic [3:0]  sh_dp, sh_blank;
  logic        sh_lz;
  logic [1:0]  sh_br;
  int          m_slot, m_t, m_pwm;
  bit          m_sup;

  // Cycle c after reset shows digit (c/DT)%N, PWM phase = position in slot.
  always @(posedge clk) begin
    if (reset) begin
      c = 0; last_phase = -1; chk_on = 1;
      exp_en = 4'hF; exp_sseg = 8'hFF; exp_ft = 1'b0;
    end else begin
      if (c % FRAME == 0) begin
        sh_hex = hex; sh_dp = dp; sh_blank = blank; sh_lz = lz_en; sh_br = bright;
      end
      exp_ft = (c % FRAME == 0);
      m_slot = (c / DT) % N;
      m_t    = c % DT;
      m_pwm  = m_t % (1 << BW);
      m_sup  = 0;
      if (m_slot > 0 && sh_lz) begin
        m_sup = 1;
        for (int j = m_slot; j < N; j++)
          if (sh_hex[4*j +: 4] != 4'h0 || sh_dp[j]) m_sup = 0;
      end
      if (!sh_blank[m_slot] && !m_sup && m_pwm <= int'(sh_br)) begin
        exp_en   = 4'hF & ~(4'b0001 << m_slot);
        exp_sseg = {~sh_dp[m_slot], ~seg_tab[sh_hex[4*m_slot +: 4]]};
      end else begin
        exp_en = 4'hF; exp_sseg = 8'hFF;
      end
      last_phase = c % FRAME;
      c++;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_en",   {4'h0, en},         {4'h0, exp_en});
      check("model_sseg", sseg,               exp_sseg);
      check("model_ft",   {7'h0, frame_tick}, {7'h0, exp_ft});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk_out(input string name, input logic [3:0] e_en, input logic [7:0] e_sseg);
    check({name, "_en"},   {4'h0, en}, {4'h0, e_en});
    check({name, "_sseg"}, sseg,       e_sseg);
  endtask

  // Wait until the outputs show frame phase p; fresh forces a later frame.
  task automatic at_phase(input int p, input bit fresh);
    int n = 0;
    if (fresh) begin
      @(negedge clk);
      while (last_phase != 0 && n < 40) begin @(negedge clk); n++; end
    end
    while (last_phase != p && n < 80) begin @(negedge clk); n++; end
    if (last_phase != p) begin
      n_tests++; n_fail++;
      $display("FAIL phase_wait: got %0d expected %0d", last_phase, p);
    end
  endtask

  task automatic set_in(input logic [15:0] h, input logic [3:0] d, input logic [3:0] b,
                        input logic lz, input logic [1:0] br);
    hex = h; dp = d; blank = b; lz_en = lz; bright = br;
  endtask

  initial begin
    set_in(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
    repeat (3) @(negedge clk);
    chk_out("in_reset", 4'hF, 8'hFF);
    reset = 1'b0;

    // Basic scan after release
    @(negedge clk);
    check("first_ft", {7'h0, frame_tick}, 8'h01);
    chk_out("slot0", 4'hE, 8'h8E);
    repeat (4) @(negedge clk); chk_out("slot1", 4'hD, 8'h88);
    repeat (4) @(negedge clk); chk_out("slot2", 4'hB, 8'hA4);
    repeat (4) @(negedge clk); chk_out("slot3", 4'h7, 8'hF9);
    repeat (4) @(negedge clk);
    check("second_ft", {7'h0, frame_tick}, 8'h01);
    chk_out("wrap_slot0", 4'hE, 8'h8E);

    // Leading-zero suppression
    set_in(16'h0050, 4'h0, 4'h0, 1'b1, 2'd3);
    at_phase(0, 1);  chk_out("lz_d0", 4'hE, 8'hC0);
    at_phase(4, 0);  chk_out("lz_d1", 4'hD, 8'h92);
    at_phase(8, 0);  chk_out("lz_d2", 4'hF, 8'hFF);
    at_phase(12, 0); chk_out("lz_d3", 4'hF, 8'hFF);
    set_in(16'h0000, 4'h0, 4'h0, 1'b1, 2'd3);
    at_phase(0, 1);  chk_out("lz0_d0", 4'hE, 8'hC0);
    at_phase(4, 0);  chk_out("lz0_d1", 4'hF, 8'hFF);
    set_in(16'h0000, 4'b0100, 4'h0, 1'b1, 2'd3);
    at_phase(4, 1);  chk_out("lzdp_d1", 4'hD, 8'hC0);
    at_phase(8, 0);  chk_out("lzdp_d2", 4'hB, 8'h40);
    at_phase(12, 0); chk_out("lzdp_d3", 4'hF, 8'hFF);

    // Blank mask and decimal point
    set_in(16'h12AF, 4'b0010, 4'b0101, 1'b0, 2'd3);
    at_phase(0, 1);  chk_out("blk_d0", 4'hF, 8'hFF);
    at_phase(4, 0);  chk_out("blk_d1", 4'hD, 8'h08);
    at_phase(8, 0);  chk_out("blk_d2", 4'hF, 8'hFF);
    at_phase(12, 0); chk_out("blk_d3", 4'h7, 8'hF9);

    // Brightness
    set_in(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd0);
    at_phase(0, 1);  chk_out("br0_t0", 4'hE, 8'h8E);
    at_phase(1, 0);  chk_out("br0_t1", 4'hF, 8'hFF);
    at_phase(4, 0);  chk_out("br0_s1t0", 4'hD, 8'h88);
    at_phase(5, 0);  chk_out("br0_s1t1", 4'hF, 8'hFF);
    set_in(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd1);
    at_phase(1, 1);  chk_out("br1_t1", 4'hE, 8'h8E);
    at_phase(2, 0);  chk_out("br1_t2", 4'hF, 8'hFF);

    // Mid-frame input change is held off until the next frame
    set_in(16'h12AF, 4'h0, 4'h0, 1'b0, 2'd3);
    at_phase(5, 1);
    hex = 16'h3456;
    at_phase(8, 0);  chk_out("hold_d2", 4'hB, 8'hA4);
    at_phase(0, 1);  chk_out("new_d0", 4'hE, 8'h82);
    at_phase(8, 0);  chk_out("new_d2", 4'hB, 8'h99);

    // Reset in slot 2
    at_phase(9, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_out("rst_mid", 4'hF, 8'hFF);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ft", {7'h0, frame_tick}, 8'h01);
    chk_out("rst_restart", 4'hE, 8'h82);

    // Random stimulus, checked by the model each cycle
    repeat (800) @(negedge clk) begin
      reset = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        for (int j = 0; j < N; j++)
          hex[4*j +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        dp     = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        blank  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
        lz_en  = 1'($urandom_range(0, 1));
        bright = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 99) == 0) reset = 1'b1;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
